// File: rtl/effect_crossfade_out_if.sv
// Sample-pair in / mixed sample out bundle for the crossfade output stage.
// Optional clip_count member is present only when CROSSFADE_CLIPCNT_EN is defined.
interface effect_crossfade_out_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 24
);
  logic signed [DATA_WIDTH-1:0] dry;
  logic signed [DATA_WIDTH-1:0] wet;
  logic                         audio_ready;
  logic                         en;
  logic signed [OUT_WIDTH-1:0]  y;
  logic                         y_valid;
  logic                         clip;
  logic [1:0]                   state;
`ifdef CROSSFADE_CLIPCNT_EN
  logic [15:0]                  clip_count;

  modport master (output dry, wet, audio_ready, en,
                  input  y, y_valid, clip, state, clip_count);
  modport slave  (input  dry, wet, audio_ready, en,
                  output y, y_valid, clip, state, clip_count);
`else
  modport master (output dry, wet, audio_ready, en,
                  input  y, y_valid, clip, state);
  modport slave  (input  dry, wet, audio_ready, en,
                  output y, y_valid, clip, state);
`endif
endinterface

// File: rtl/effect_crossfade_out.sv
// Dry/wet crossfader with linear gain ramp on enable changes, saturating to codec width.
// Fixed 3-cycle latency, one sample per cycle, no backpressure; CROSSFADE_CLIPCNT_EN adds clip_count.
module effect_crossfade_out #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 24,
  parameter int GAIN_WIDTH = 8,
  parameter int FADE_STEP  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  effect_crossfade_out_if.slave  io_xf
);
  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 2;
  localparam int SW = DATA_WIDTH + 2;
  localparam logic [GAIN_WIDTH:0] G_MAX = {1'b1, {GAIN_WIDTH{1'b0}}};
  localparam logic [GAIN_WIDTH:0] STEP  = (GAIN_WIDTH+1)'(FADE_STEP);
  localparam logic signed [SW-1:0] Y_MAX = SW'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [SW-1:0] Y_MIN = SW'(-(64'sd1 <<< (OUT_WIDTH-1)));

  typedef enum logic [1:0] {
    S_DRY      = 2'd0,
    S_FADE_IN  = 2'd1,
    S_WET      = 2'd2,
    S_FADE_OUT = 2'd3
  } state_t;

  state_t                  r_state;
  logic [GAIN_WIDTH:0]     r_g;
  logic                    r_v1, r_v2, r_y_valid;
  logic signed [PW-1:0]    r_pw, r_pd;
  logic signed [SW-1:0]    r_s;
  logic signed [OUT_WIDTH-1:0] r_y;
  logic                    r_clip;

  logic [GAIN_WIDTH+1:0]   w_g_sum;
  logic [GAIN_WIDTH:0]     w_g_up, w_g_dn;
  logic signed [PW-1:0]    w_wet_x, w_dry_x, w_g_x, w_gc_x, w_pw, w_pd, w_mix;
  logic signed [SW-1:0]    w_shift;
  logic                    w_hi, w_lo;
  logic signed [OUT_WIDTH-1:0] w_y_sat;

  assign w_g_sum = {1'b0, r_g} + {1'b0, STEP};
  assign w_g_up  = (w_g_sum >= {1'b0, G_MAX}) ? G_MAX : w_g_sum[GAIN_WIDTH:0];
  assign w_g_dn  = (r_g > STEP) ? (r_g - STEP) : '0;

  // FSM and gain move only on strobes; a reversal keeps g for that sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_DRY;
      r_g     <= '0;
    end else if (io_xf.audio_ready) begin
      unique case (r_state)
        S_DRY: if (io_xf.en) begin
          r_g     <= w_g_up;
          r_state <= (w_g_up == G_MAX) ? S_WET : S_FADE_IN;
        end
        S_FADE_IN: if (!io_xf.en) begin
          r_state <= S_FADE_OUT;
        end else begin
          r_g <= w_g_up;
          if (w_g_up == G_MAX) r_state <= S_WET;
        end
        S_WET: if (!io_xf.en) begin
          r_g     <= w_g_dn;
          r_state <= (w_g_dn == '0) ? S_DRY : S_FADE_OUT;
        end
        S_FADE_OUT: if (io_xf.en) begin
          r_state <= S_FADE_IN;
        end else begin
          r_g <= w_g_dn;
          if (w_g_dn == '0) r_state <= S_DRY;
        end
        default: r_state <= S_DRY;
      endcase
    end
  end

  assign w_wet_x = {{(PW-DATA_WIDTH){io_xf.wet[DATA_WIDTH-1]}}, io_xf.wet};
  assign w_dry_x = {{(PW-DATA_WIDTH){io_xf.dry[DATA_WIDTH-1]}}, io_xf.dry};
  assign w_g_x   = {{(PW-GAIN_WIDTH-1){1'b0}}, r_g};
  assign w_gc_x  = {{(PW-GAIN_WIDTH-1){1'b0}}, G_MAX - r_g};
  assign w_pw    = w_wet_x * w_g_x;
  assign w_pd    = w_dry_x * w_gc_x;
  assign w_mix   = r_pw + r_pd;
  assign w_shift = SW'(w_mix >>> GAIN_WIDTH);

  assign w_hi    = (r_s > Y_MAX);
  assign w_lo    = (r_s < Y_MIN);
  assign w_y_sat = w_hi ? Y_MAX[OUT_WIDTH-1:0] :
                   w_lo ? Y_MIN[OUT_WIDTH-1:0] : r_s[OUT_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_y_valid <= 1'b0;
      r_pw      <= '0;
      r_pd      <= '0;
      r_s       <= '0;
      r_y       <= '0;
      r_clip    <= 1'b0;
    end else begin
      r_v1      <= io_xf.audio_ready;
      r_v2      <= r_v1;
      r_y_valid <= r_v2;
      if (io_xf.audio_ready) begin
        r_pw <= w_pw;
        r_pd <= w_pd;
      end
      if (r_v1) r_s <= w_shift;
      if (r_v2) begin
        r_y    <= w_y_sat;
        r_clip <= w_hi | w_lo;
      end
    end
  end

  assign io_xf.y       = r_y;
  assign io_xf.y_valid = r_y_valid;
  assign io_xf.clip    = r_clip;
  assign io_xf.state   = r_state;

`ifdef CROSSFADE_CLIPCNT_EN
  logic        r_en_last;
  logic [15:0] r_clip_count;

  // A fresh enable edge restarts the count, taking priority over a same-cycle clip
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en_last    <= 1'b0;
      r_clip_count <= '0;
    end else begin
      if (io_xf.audio_ready) r_en_last <= io_xf.en;
      if (io_xf.audio_ready && io_xf.en && !r_en_last)
        r_clip_count <= '0;
      else if (r_v2 && (w_hi | w_lo) && (r_clip_count != 16'hFFFF))
        r_clip_count <= r_clip_count + 16'd1;
    end
  end

  assign io_xf.clip_count = r_clip_count;
`endif
endmodule

// File: tb/tb_effect_crossfade_out.sv
// Bench for effect_crossfade_out: arithmetic reference model checked every cycle plus literal pins.
module tb_effect_crossfade_out;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  effect_crossfade_out_if #(.DATA_WIDTH(32), .OUT_WIDTH(24)) bus ();

  effect_crossfade_out #(
    .DATA_WIDTH(32), .OUT_WIDTH(24), .GAIN_WIDTH(8), .FADE_STEP(4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_xf (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit armed = 1'b0;

  typedef struct { int due; longint y; bit clip; } exp_t;
  exp_t   q[$];
  int     m_st, m_g;
  bit     m_vld, m_clip, m_en_last;
  longint m_y;
  int     m_cnt;
  longint log_y[$];
  bit     log_clip[$];

  task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: y = sat(floor((wet*g + dry*(256-g))/256)), due 3 cycles after the strobe
  always @(posedge clk) begin
    exp_t e;
    longint num, s;
    cyc++;
    if (rst) begin
      q.delete();
      m_st = 0; m_g = 0; m_vld = 0; m_y = 0; m_clip = 0; m_en_last = 0; m_cnt = 0;
    end else begin
      m_vld = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        m_vld = 1; m_y = e.y; m_clip = e.clip;
        if (e.clip && m_cnt < 65535) m_cnt++;
      end
      if (bus.audio_ready) begin
        num = longint'(bus.wet) * m_g + longint'(bus.dry) * (256 - m_g);
        s = num / 256;
        if (num % 256 != 0 && num < 0) s = s - 1;
        e.due  = cyc + 2;
        e.clip = (s > 8388607) || (s < -8388608);
        e.y    = (s > 8388607) ? 8388607 : (s < -8388608) ? -8388608 : s;
        q.push_back(e);
        if (bus.en && !m_en_last) m_cnt = 0;
        m_en_last = bus.en;
        if (bus.en) begin
          if (m_st == 3) m_st = 1;
          else if (m_st != 2) begin
            m_g = (m_g + 4 > 256) ? 256 : m_g + 4;
            m_st = (m_g == 256) ? 2 : 1;
          end
        end else begin
          if (m_st == 1) m_st = 3;
          else if (m_st != 0) begin
            m_g = (m_g - 4 < 0) ? 0 : m_g - 4;
            m_st = (m_g == 0) ? 0 : 3;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("y_valid", {63'd0, bus.y_valid}, {63'd0, m_vld});
      check("y", 64'($signed(bus.y)), m_y);
      check("clip", {63'd0, bus.clip}, {63'd0, m_clip});
      check("state", {62'd0, bus.state}, 64'(m_st));
`ifdef CROSSFADE_CLIPCNT_EN
      check("clip_count", {48'd0, bus.clip_count}, 64'(m_cnt));
`endif
      if (bus.y_valid === 1'b1) begin
        log_y.push_back(64'($signed(bus.y)));
        log_clip.push_back(bus.clip);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input int e, input int d, input int w);
    bus.en = e[0];
    bus.dry = d;
    bus.wet = w;
    bus.audio_ready = 1'b1;
    tick();
    bus.audio_ready = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.dry = '0; bus.wet = '0; bus.audio_ready = 1'b0;
    rst = 1'b1;
    idle(2);
    armed = 1'b1;
    check("reset_y", 64'($signed(bus.y)), 0);
    check("reset_state", {62'd0, bus.state}, 0);
    rst = 1'b0;

    // dry path: output lands exactly 3 cycles after each strobe
    for (int i = 0; i < 3; i++) begin
      strobe(0, 1000, -5);
      tick();
      check("dry_early", {63'd0, bus.y_valid}, 0);
      tick();
      check("dry_valid", {63'd0, bus.y_valid}, 1);
      check("dry_y", 64'($signed(bus.y)), 1000);
      idle(5);
    end

    // fade-in ramp, back-to-back strobes
    log_y.delete(); log_clip.delete();
    for (int i = 1; i <= 70; i++) begin
      strobe(1, 0, 25600);
      if (i == 63) check("fadein_state63", {62'd0, bus.state}, 1);
      if (i == 64) check("fadein_state64", {62'd0, bus.state}, 2);
    end
    idle(5);
    check("fadein_count", 64'(log_y.size()), 70);
    if (log_y.size() == 70) begin
      check("fadein_y0", log_y[0], 0);
      check("fadein_y1", log_y[1], 400);
      check("fadein_y2", log_y[2], 800);
      check("fadein_y63", log_y[63], 25200);
      check("fadein_y64", log_y[64], 25600);
      check("fadein_y69", log_y[69], 25600);
    end

    // reset mid-fade with strobes in flight
    for (int i = 0; i < 64; i++) strobe(0, 0, 25600);
    idle(4);
    for (int i = 0; i < 5; i++) strobe(1, 0, 25600);
    rst = 1'b1;
    bus.audio_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    bus.audio_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_y_valid", {63'd0, bus.y_valid}, 0);
      check("rst_y", 64'($signed(bus.y)), 0);
      check("rst_clip", {63'd0, bus.clip}, 0);
      check("rst_state", {62'd0, bus.state}, 0);
      tick();
    end

    // reversal after 10 fade-in steps (g=40)
    log_y.delete(); log_clip.delete();
    for (int i = 1; i <= 22; i++) begin
      strobe((i <= 10) ? 1 : 0, 0, 25600);
      if (i == 11) check("rev_state11", {62'd0, bus.state}, 3);
      if (i == 20) check("rev_state20", {62'd0, bus.state}, 3);
      if (i == 21) check("rev_state21", {62'd0, bus.state}, 0);
    end
    idle(5);
    if (log_y.size() == 22) begin
      check("rev_y10", log_y[10], 4000);
      check("rev_y11", log_y[11], 4000);
      check("rev_y12", log_y[12], 3600);
      check("rev_y21", log_y[21], 0);
    end else check("rev_count", 64'(log_y.size()), 22);

    // saturation at full wet
    for (int i = 0; i < 64; i++) strobe(1, 0, 0);
    idle(5);
    log_y.delete(); log_clip.delete();
    strobe(1, 0, 32'sh0100_0000);
    strobe(1, 0, -32'sh0100_0000);
    strobe(1, 0, 5);
    idle(5);
    if (log_y.size() == 3) begin
      check("sat_hi_y", log_y[0], 8388607);
      check("sat_hi_clip", {63'd0, log_clip[0]}, 1);
      check("sat_lo_y", log_y[1], -8388608);
      check("sat_lo_clip", {63'd0, log_clip[1]}, 1);
      check("sat_none_y", log_y[2], 5);
      check("sat_none_clip", {63'd0, log_clip[2]}, 0);
    end else check("sat_count", 64'(log_y.size()), 3);

`ifdef CROSSFADE_CLIPCNT_EN
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      strobe(0, 32'sh0100_0000, 0);
      idle(2);
      check("clipcnt_inc", {48'd0, bus.clip_count}, 64'(i));
      idle(2);
    end
    strobe(1, 0, 0);
    check("clipcnt_clear", {48'd0, bus.clip_count}, 0);
    idle(5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
